// File: rtl/senha_enroll_pkg.sv
// Shared definitions for the password enrollment engine: table geometry,
// free-slot marker, status codes and FSM state encoding.
package senha_enroll_pkg;

    localparam int         ADDR_W = 5;
    localparam int         DEPTH  = 2 ** ADDR_W;
    localparam logic [7:0] EMPTY  = 8'h00;

    typedef enum logic [2:0] {
        ST_NONE      = 3'd0,
        ST_OK        = 3'd1,
        ST_DUP       = 3'd2,
        ST_FULL      = 3'd3,
        ST_NOT_FOUND = 3'd4,
        ST_INVALID   = 3'd5
    } status_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SCAN   = 3'd1,
        S_LAST   = 3'd2,
        S_WRITE  = 3'd3,
        S_REPORT = 3'd4
    } state_t;

endpackage

// File: rtl/senha_enroll_if.sv
// Command strobe, status and password-RAM port bundle for senha_enroll.
// slave = the engine, master = whoever drives commands and models the RAM.
interface senha_enroll_if;

    logic                                enter;
    logic                                mode;
    logic [7:0]                          senha_in;
    logic [7:0]                          mem_q;
    logic [senha_enroll_pkg::ADDR_W-1:0] mem_addr;
    logic [7:0]                          mem_wdata;
    logic                                mem_we;
    logic                                busy;
    logic                                done;
    logic [2:0]                          status;

    modport slave (
        input  enter, mode, senha_in, mem_q,
        output mem_addr, mem_wdata, mem_we, busy, done, status
    );

    modport master (
        output enter, mode, senha_in, mem_q,
        input  mem_addr, mem_wdata, mem_we, busy, done, status
    );

endinterface

// File: rtl/senha_enroll_binary_counter.sv
// Scan address counter: synchronous clear, count enable, terminal-count flag.
// Output is the registered count; o_fc is high while the count is all ones.
module senha_enroll_binary_counter #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_q,
    output logic             o_fc
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= r_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign o_q  = r_q;
    assign o_fc = &r_q;

endmodule

// File: rtl/senha_enroll.sv
// Password add/remove engine: full table scan, at most one RAM write, status report.
// Latency DEPTH+3 cycles with a write, DEPTH+2 without; enter outside IDLE is dropped.
module senha_enroll
    import senha_enroll_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    senha_enroll_if.slave bus
);

    state_t              r_state, w_state_n;
    status_t             r_status, w_res;
    logic                r_mode;
    logic [7:0]          r_senha;
    logic                r_match_vld, r_free_vld;
    logic [ADDR_W-1:0]   r_match_addr, r_free_addr;
    logic                r_cmp_vld;
    logic [ADDR_W-1:0]   r_cmp_addr;
    logic [ADDR_W-1:0]   r_wr_addr, w_wr_addr;
    logic [7:0]          r_wr_data, w_wr_data;

    logic [ADDR_W-1:0]   w_cnt;
    logic                w_fc, w_cnt_rst, w_cnt_en;
    logic                w_hit, w_free, w_we;
    logic                w_match_vld, w_free_vld;
    logic [ADDR_W-1:0]   w_match_addr, w_free_addr;

    assign w_cnt_rst = rst | (r_state == S_IDLE);
    assign w_cnt_en  = (r_state == S_SCAN);

    senha_enroll_binary_counter #(.WIDTH(ADDR_W)) u_binary_counter (
        .clk  (clk),
        .rst  (w_cnt_rst),
        .i_en (w_cnt_en),
        .o_q  (w_cnt),
        .o_fc (w_fc)
    );

    // mem_q lags the address by one cycle, so compare against the address issued last cycle.
    assign w_hit        = r_cmp_vld && (bus.mem_q == r_senha);
    assign w_free       = r_cmp_vld && (bus.mem_q == EMPTY);
    assign w_match_vld  = r_match_vld | w_hit;
    assign w_match_addr = r_match_vld ? r_match_addr : r_cmp_addr;
    assign w_free_vld   = r_free_vld | w_free;
    assign w_free_addr  = r_free_vld ? r_free_addr : r_cmp_addr;

    always_comb begin
        w_state_n = r_state;
        w_res     = ST_NONE;
        w_wr_addr = r_wr_addr;
        w_wr_data = r_wr_data;
        case (r_state)
            S_IDLE: begin
                if (bus.enter) begin
                    if (bus.senha_in == EMPTY) begin
                        w_state_n = S_REPORT;
                        w_res     = ST_INVALID;
                    end else begin
                        w_state_n = S_SCAN;
                    end
                end
            end
            S_SCAN: begin
                if (w_fc) w_state_n = S_LAST;
            end
            S_LAST: begin
                w_state_n = S_REPORT;
                if (!r_mode) begin
                    if (w_match_vld) begin
                        w_res = ST_DUP;
                    end else if (w_free_vld) begin
                        w_state_n = S_WRITE;
                        w_wr_addr = w_free_addr;
                        w_wr_data = r_senha;
                    end else begin
                        w_res = ST_FULL;
                    end
                end else begin
                    if (w_match_vld) begin
                        w_state_n = S_WRITE;
                        w_wr_addr = w_match_addr;
                        w_wr_data = EMPTY;
                    end else begin
                        w_res = ST_NOT_FOUND;
                    end
                end
            end
            S_WRITE: begin
                w_state_n = S_REPORT;
                w_res     = ST_OK;
            end
            S_REPORT: w_state_n = S_IDLE;
            default:  w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_status     <= ST_NONE;
            r_mode       <= 1'b0;
            r_senha      <= '0;
            r_match_vld  <= 1'b0;
            r_match_addr <= '0;
            r_free_vld   <= 1'b0;
            r_free_addr  <= '0;
            r_cmp_vld    <= 1'b0;
            r_cmp_addr   <= '0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
        end else begin
            r_state    <= w_state_n;
            r_cmp_vld  <= (r_state == S_SCAN);
            r_cmp_addr <= w_cnt;
            r_wr_addr  <= w_wr_addr;
            r_wr_data  <= w_wr_data;
            if (r_state == S_IDLE && bus.enter) begin
                r_mode      <= bus.mode;
                r_senha     <= bus.senha_in;
                r_match_vld <= 1'b0;
                r_free_vld  <= 1'b0;
            end else begin
                r_match_vld  <= w_match_vld;
                r_match_addr <= w_match_addr;
                r_free_vld   <= w_free_vld;
                r_free_addr  <= w_free_addr;
            end
            // Status lands on REPORT entry so it is valid in the same cycle as done.
            if (w_state_n == S_REPORT && r_state != S_REPORT) r_status <= w_res;
        end
    end

    assign w_we          = (r_state == S_WRITE) && !rst;
    assign bus.mem_we    = w_we;
    assign bus.mem_addr  = (r_state == S_WRITE) ? r_wr_addr : w_cnt;
    assign bus.mem_wdata = w_we ? r_wr_data : 8'h00;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_REPORT);
    assign bus.status    = r_status;

endmodule
